// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: ALU op codes, RV32I opcodes and the issue packet.
package alu_issue_pkg;

  localparam int XLEN = 32;

  // Codes with bit 3 set are evaluated on the subtractor in EX.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SLR = 4'b0101,
    ALU_SAR = 4'b0110,
    ALU_SUB = 4'b1000,
    ALU_BEQ = 4'b1001,
    ALU_BNE = 4'b1010,
    ALU_BLT = 4'b1011,
    ALU_BGE = 4'b1100
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    alu_op_e         alu_op;
    logic [4:0]      rd;
    logic            wb_en;
    logic            is_branch;
    logic [XLEN-1:0] br_target;
    logic            illegal;
  } issue_pkt_t;

  localparam int PKT_W = $bits(issue_pkt_t);

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into an issue packet; zero latency, no flow control.
// Unsupported encodings yield an ADD 0,0 packet flagged illegal with no writeback.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_pkt_t      pkt
);

  logic [6:0]      opcode;
  logic [4:0]      rd_f;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] shamt;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign shamt  = {27'b0, instr[24:20]};

  alu_op_e         op_sel;
  logic [XLEN-1:0] a_sel;
  logic [XLEN-1:0] b_sel;
  logic            legal;
  logic            branch;
  logic            has_rd;

  always_comb begin
    op_sel = ALU_ADD;
    a_sel  = '0;
    b_sel  = '0;
    legal  = 1'b0;
    branch = 1'b0;
    has_rd = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        a_sel  = rs1_data;
        b_sel  = rs2_data;
        has_rd = 1'b1;
        legal  = 1'b1;
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000:  op_sel = ALU_ADD;
            3'b001:  op_sel = ALU_SLL;
            3'b100:  op_sel = ALU_XOR;
            3'b101:  op_sel = ALU_SLR;
            3'b110:  op_sel = ALU_OR;
            3'b111:  op_sel = ALU_AND;
            default: legal  = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          unique case (funct3)
            3'b000:  op_sel = ALU_SUB;
            3'b101:  op_sel = ALU_SAR;
            default: legal  = 1'b0;
          endcase
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        a_sel  = rs1_data;
        b_sel  = imm_i;
        has_rd = 1'b1;
        legal  = 1'b1;
        unique case (funct3)
          3'b000: op_sel = ALU_ADD;
          3'b100: op_sel = ALU_XOR;
          3'b110: op_sel = ALU_OR;
          3'b111: op_sel = ALU_AND;
          3'b001: begin
            op_sel = ALU_SLL;
            b_sel  = shamt;
            legal  = (funct7 == F7_BASE);
          end
          3'b101: begin
            b_sel = shamt;
            if (funct7 == F7_BASE)     op_sel = ALU_SLR;
            else if (funct7 == F7_ALT) op_sel = ALU_SAR;
            else                       legal  = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        b_sel  = imm_u;
        has_rd = 1'b1;
        legal  = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel  = pc;
        b_sel  = imm_u;
        has_rd = 1'b1;
        legal  = 1'b1;
      end
      OPC_BRANCH: begin
        a_sel  = rs1_data;
        b_sel  = rs2_data;
        branch = 1'b1;
        legal  = 1'b1;
        unique case (funct3)
          3'b000:  op_sel = ALU_BEQ;
          3'b001:  op_sel = ALU_BNE;
          3'b100:  op_sel = ALU_BLT;
          3'b101:  op_sel = ALU_BGE;
          default: legal  = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Branches and illegal packets carry no destination, so rd is forced to 0.
  always_comb begin
    pkt = '0;
    if (legal) begin
      pkt.alu_a     = a_sel;
      pkt.alu_b     = b_sel;
      pkt.alu_op    = op_sel;
      pkt.rd        = has_rd ? rd_f : 5'd0;
      pkt.wb_en     = has_rd && (rd_f != 5'd0);
      pkt.is_branch = branch;
      pkt.br_target = branch ? (pc + imm_b) : '0;
    end else begin
      pkt.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_skid_buf.sv
// Generic 2-entry registered skid buffer (main + skid), strict FIFO order, 1-cycle latency.
// in_rdy is registered and drops the cycle after skid fills; data is zero whenever an entry is empty.
module alu_skid_buf #(
  parameter int W = 108
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_dat_q, main_dat_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         in_rdy_q, in_rdy_d;
  logic         push;
  logic         pop;

  assign push = in_vld && in_rdy_q;
  assign pop  = main_vld_q && out_rdy;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      main_vld_d = 1'b0;
      main_dat_d = '0;
      skid_vld_d = 1'b0;
      skid_dat_d = '0;
    end else if (skid_vld_q) begin
      // Full: in_rdy_q is low, so only a pop can happen here.
      if (pop) begin
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
        skid_dat_d = '0;
      end
    end else if (main_vld_q) begin
      if (pop && push) begin
        main_dat_d = in_dat;
      end else if (pop) begin
        main_vld_d = 1'b0;
        main_dat_d = '0;
      end else if (push) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_dat;
      end
    end else if (push) begin
      main_vld_d = 1'b1;
      main_dat_d = in_dat;
    end
    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      in_rdy_q   <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = main_vld_q;
  assign out_dat = main_dat_q;

endmodule

// File: rtl/alu_issue.sv
// RV32I issue stage: decode into ALU op/operands, then a 2-entry skid buffer; 1-cycle latency.
// EX backpressure via out_ready; in_ready is registered and falls once both entries are held.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            wb_en,
  output logic            is_branch,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  issue_pkt_t       dec_pkt;
  issue_pkt_t       buf_pkt;
  logic [PKT_W-1:0] buf_dat;

  alu_issue_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .pkt      (dec_pkt)
  );

  alu_skid_buf #(
    .W (PKT_W)
  ) u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (dec_pkt),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (buf_dat)
  );

  assign buf_pkt   = buf_dat;
  assign alu_a     = buf_pkt.alu_a;
  assign alu_b     = buf_pkt.alu_b;
  assign alu_op    = buf_pkt.alu_op;
  assign rd        = buf_pkt.rd;
  assign wb_en     = buf_pkt.wb_en;
  assign is_branch = buf_pkt.is_branch;
  assign br_target = buf_pkt.br_target;
  assign illegal   = buf_pkt.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed cases plus randomized traffic against a mnemonic-level model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [31:0] alu_a, alu_b, br_target;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        wb_en, is_branch, illegal;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd),
    .wb_en(wb_en), .is_branch(is_branch), .br_target(br_target), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t       q[$];
  logic [4:0] emit_log[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 0;
  bit         last_acc = 0;
  bit         rdy_s;
  bit         snap_vld, snap_rdy;
  exp_t       snap;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: classify the mnemonic, then build the packet from the ISA definitions.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pcv,
                                     input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] bi;
    logic        ok, br, has_rd;
    logic [3:0]  op;
    logic [31:0] a, b;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 0; br = 0; has_rd = 0; op = 4'd0; a = 0; b = 0;
    case (opc)
      7'h33: begin
        a = r1; b = r2; has_rd = 1;
        if (f7 == 7'h00) begin
          ok = (f3 != 3'd2) && (f3 != 3'd3);
          op = (f3 == 0) ? 4'd0 : (f3 == 1) ? 4'd4 : (f3 == 4) ? 4'd3 :
               (f3 == 5) ? 4'd5 : (f3 == 6) ? 4'd2 : 4'd1;
        end else if (f7 == 7'h20) begin
          ok = (f3 == 3'd0) || (f3 == 3'd5);
          op = (f3 == 0) ? 4'd8 : 4'd6;
        end
      end
      7'h13: begin
        a = r1; b = 32'($signed(ins) >>> 20); has_rd = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b  = {27'd0, ins[24:20]};
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
          op = (f3 == 1) ? 4'd4 : (f7 == 7'h00) ? 4'd5 : 4'd6;
        end else begin
          ok = (f3 != 3'd2) && (f3 != 3'd3);
          op = (f3 == 0) ? 4'd0 : (f3 == 4) ? 4'd3 : (f3 == 6) ? 4'd2 : 4'd1;
        end
      end
      7'h37: begin ok = 1; has_rd = 1; b = ins & 32'hFFFF_F000; end
      7'h17: begin ok = 1; has_rd = 1; a = pcv; b = ins & 32'hFFFF_F000; end
      7'h63: begin
        a = r1; b = r2; br = 1;
        ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
        op = 4'd9 + {3'd0, f3[0]} + (f3[2] ? 4'd2 : 4'd0);
      end
      default: ok = 0;
    endcase
    e = '0;
    if (!ok) begin
      e.ill = 1;
    end else begin
      bi    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      e.a   = a;
      e.b   = b;
      e.op  = op;
      e.br  = br;
      e.rd  = has_rd ? ins[11:7] : 5'd0;
      e.wb  = has_rd && (ins[11:7] != 5'd0);
      e.tgt = br ? pcv + {{19{bi[12]}}, bi} : 32'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h63;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: snapshot outputs at the falling edge, book the handshake at the rising edge.
  task automatic step();
    @(negedge clk);
    rdy_s    = in_ready;
    snap_vld = out_valid;
    snap_rdy = in_ready;
    snap     = {alu_a, alu_b, alu_op, rd, wb_en, is_branch, br_target, illegal};
    @(posedge clk);
    last_acc = 0;
    if (rst || flush) begin
      q.delete();
    end else if (in_valid && rdy_s) begin
      q.push_back(ref_model(instr, pc, rs1_data, rs2_data));
      last_acc = 1;
    end
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 0;
    instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1;
    for (int n = 0; n < 20 && !ok; n++) begin
      step();
      ok = last_acc;
    end
    in_valid = 0;
    chk("send_accepted", ok, 1);
  endtask

  // Monitor: compares every presented packet with the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (out_valid && q.size() > 0) begin
          chk("packet", {alu_a, alu_b, alu_op, rd, wb_en, is_branch, br_target, illegal}, q[0]);
          if (out_ready && !rst) begin
            emit_log.push_back(q[0].rd);
            void'(q.pop_front());
          end
        end else if (!out_valid) begin
          chk("idle_zero", {alu_a, alu_b, alu_op, rd, wb_en, is_branch, br_target, illegal}, 0);
        end
      end
    end
  end

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    step(); step();
    rst = 0; mon_en = 1;
    step();
    chk("reset_in_ready", snap_rdy, 1);
    chk("reset_out_valid", snap_vld, 0);
    chk("reset_outputs", snap, 0);

    out_ready = 1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    chk("add_valid", snap_vld, 1);
    chk("add_op", snap.op, 4'b0000);
    chk("add_ab", {snap.a, snap.b}, {32'd5, 32'd7});
    chk("add_rd_wb_ill", {snap.rd, snap.wb, snap.ill}, {5'd3, 1'b1, 1'b0});

    send(32'h4040D093, 32'h4, 32'h8000_0000, 32'd0);
    step();
    chk("srai_op", snap.op, 4'b0110);
    chk("srai_ab", {snap.a, snap.b}, {32'h8000_0000, 32'd4});
    chk("srai_rd_wb", {snap.rd, snap.wb}, {5'd1, 1'b1});

    send(32'h00208463, 32'h100, 32'd9, 32'd9);
    step();
    chk("beq_op", snap.op, 4'b1001);
    chk("beq_br_wb", {snap.br, snap.wb}, {1'b1, 1'b0});
    chk("beq_target", snap.tgt, 32'h108);

    send(32'h0020A1B3, 32'h8, 32'd11, 32'd12);
    step();
    chk("slt_ill_wb", {snap.ill, snap.wb}, {1'b1, 1'b0});
    chk("slt_ab", {snap.a, snap.b}, 64'd0);

    // Backpressure: two accepts fill the buffer, the third is held off.
    emit_log.delete();
    out_ready = 0;
    send(32'h00100093, 32'h10, 32'd0, 32'd0);
    send(32'h00200113, 32'h14, 32'd0, 32'd0);
    instr = 32'h00300193; pc = 32'h18; in_valid = 1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("bp_in_ready_low", snap_rdy, 0);
      chk("bp_no_accept", last_acc, 0);
      chk("bp_stable_head", {snap_vld, snap.rd, snap.b}, {1'b1, 5'd1, 32'd1});
    end
    out_ready = 1;
    send(32'h00300193, 32'h18, 32'd0, 32'd0);
    repeat (4) step();
    chk("bp_count", emit_log.size(), 3);
    for (int n = 0; n < 3 && n < emit_log.size(); n++)
      chk("bp_order", emit_log[n], n + 1);

    // Flush with a full buffer, then with a single entry and a packet that would be accepted.
    emit_log.delete();
    out_ready = 0;
    send(32'h00400213, 32'h20, 32'd0, 32'd0);
    send(32'h00500293, 32'h24, 32'd0, 32'd0);
    flush = 1; instr = 32'h00600313; in_valid = 1;
    step();
    flush = 0; in_valid = 0;
    step();
    chk("flush_full_out_valid", snap_vld, 0);
    chk("flush_full_in_ready", snap_rdy, 1);
    send(32'h00700393, 32'h28, 32'd0, 32'd0);
    flush = 1; instr = 32'h00800413; in_valid = 1;
    step();
    flush = 0; in_valid = 0;
    step();
    chk("flush_one_out_valid", snap_vld, 0);
    out_ready = 1;
    repeat (3) step();
    chk("flush_nothing_emitted", emit_log.size(), 0);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      instr     = gen_instr();
      pc        = $urandom & 32'hFFFF_FFFC;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      step();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (4) step();
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
